rgb_to_gray_arbiter: RTL
========================

Name: rgb_to_gray_arbiter

Overview:
Round-robin arbiter and sequencer that shares one multi-cycle RGB-to-gray conversion core among NUM_REQ pixel requesters.
- Accepts one pixel at a time over a valid/ready handshake.
- Issues the pixel to the core and holds R/G/B stable until the core reports completion.
- Returns the 32-bit GRAY result to the originating requester over a valid/ready response handshake.
- Sits between pixel producers and the conversion core's top level.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
ID_W, 2, width of requester index; must satisfy 2**ID_W >= NUM_REQ
TIMEOUT_CYCLES, 64, watchdog limit in WAIT (used only with RGB_ARB_TIMEOUT_EN)

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous reset, active-high
req_valid  input  NUM_REQ  per-requester pixel valid
req_rgb  input  NUM_REQ*24  packed pixels; requester i at [24i+23:24i], ordered {R,G,B}
req_ready  output  NUM_REQ  one-hot accept strobe
resp_valid  output  NUM_REQ  one-hot result valid
resp_ready  input  NUM_REQ  per-requester result accept
resp_gray  output  32  result data, shared by all requesters
core_input_valid  output  1  start pulse to the core
core_R, core_G, core_B  output  8 each  pixel to the core
core_output_valid  input  1  core done pulse
core_gray  input  32  core result
busy  output  1  high whenever state != IDLE

Behaviour:
- Clock and reset: single clock clk; rst is asynchronous, active-high.
- Reset values:
  - state = IDLE; rr_ptr = NUM_REQ-1, so requester 0 has first priority.
  - All outputs are 0, including core_R/G/B, resp_gray, req_ready, resp_valid and busy.
- State machine: IDLE -> ISSUE -> WAIT -> RESP -> IDLE.
- IDLE:
  - Grant goes to the first asserted req_valid searching from (rr_ptr+1) mod NUM_REQ upward, with wrap-around.
  - req_ready[grant] is combinational and asserted only in IDLE. The handshake completes in the same cycle.
  - On the handshake:
    - latch req_rgb[grant] into core_R/G/B and grant into cur_id;
    - set rr_ptr = grant;
    - go to ISSUE.
  - With no req_valid asserted, stay in IDLE and keep req_ready = 0.
- ISSUE: core_input_valid = 1 for exactly one cycle, then go to WAIT.
- WAIT:
  - core_R/G/B are held constant.
  - When core_output_valid = 1, latch core_gray into resp_gray and go to RESP.
- RESP:
  - resp_valid[cur_id] = 1 is registered; resp_gray is stable.
  - Stay in RESP until resp_ready[cur_id] = 1, then clear resp_valid and go to IDLE.
  - resp_ready from any other requester is ignored.
- Latency from accept (cycle T):
  - core_input_valid is high at T+1.
  - resp_valid rises the cycle after core_output_valid.
  - Minimum response latency: accept-to-return is T+1+core latency+1.
  - Minimum repeat interval: the next accept can occur in the cycle after the RESP handshake.
- Ignored and corner cases:
  - core_output_valid outside WAIT is ignored, with no state change.
  - req_valid dropping before grant: the request is simply not granted. req_rgb is sampled only in the handshake cycle.
  - A single requester asserting continuously is served back-to-back; fairness holds when others assert.
  - Reset mid-operation: immediate return to IDLE with all outputs zeroed. The in-flight pixel is dropped and no response is issued.

Optional Feature:
Macro RGB_ARB_TIMEOUT_EN.
- Defined:
  - Adds output err_timeout (1 bit, reset 0).
  - A counter counts cycles in WAIT; when it reaches TIMEOUT_CYCLES without core_output_valid:
    - err_timeout pulses for one cycle;
    - resp_gray = 32'hFFFF_FFFF;
    - the block goes to RESP, and the requester still receives a response.
  - The counter clears on entry to WAIT.
- Not defined: no counter and no err_timeout port; WAIT waits indefinitely.

Test Plan:
Bench core model: GRAY = R+G+B, returned 5 cycles after input_valid.
- Reset then a single request: req_valid = 4'b0001, rgb = {8'd10,8'd20,8'd30} -> req_ready[0] in the same cycle, core_input_valid one cycle later; resp_valid[0] with resp_gray = 60; core_R/G/B stable throughout WAIT.
- All four valid continuously, resp_ready = 1 -> grants in order 0,1,2,3,0; exactly one resp_valid per grant, matching each requester's pixel sum.
- resp_ready[2] held low 10 cycles with requester 2 in RESP -> resp_valid[2] and resp_gray held; no new grant; resp_ready[1] = 1 during this time has no effect.
- Spurious core_output_valid pulse in IDLE and in RESP -> no state change, resp_gray unchanged.
- rst asserted during WAIT -> all outputs 0 asynchronously; next request from requester 3 with requester 0 also valid -> requester 0 granted first.
- With RGB_ARB_TIMEOUT_EN, core model never responds -> err_timeout pulse after 64 WAIT cycles, resp_gray = 32'hFFFFFFFF delivered to the requester.

Source files
------------

// File: rtl/rgb_to_gray_arbiter.sv
// rgb_to_gray_arbiter: round-robin sharing of one multi-cycle RGB-to-gray core among NUM_REQ requesters.
// Optional WAIT watchdog with err_timeout output enabled by macro RGB_ARB_TIMEOUT_EN.
module rgb_to_gray_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ID_W = 2,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_REQ-1:0]   req_valid,
  input  logic [NUM_REQ*24-1:0] req_rgb,
  output logic [NUM_REQ-1:0]   req_ready,
  output logic [NUM_REQ-1:0]   resp_valid,
  input  logic [NUM_REQ-1:0]   resp_ready,
  output logic [31:0]          resp_gray,
  output logic                 core_input_valid,
  output logic [7:0]           core_R,
  output logic [7:0]           core_G,
  output logic [7:0]           core_B,
  input  logic                 core_output_valid,
  input  logic [31:0]          core_gray,
`ifdef RGB_ARB_TIMEOUT_EN
  output logic                 err_timeout,
`endif
  output logic                 busy
);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;
  state_t state;
  logic [ID_W-1:0] rr_ptr;
  logic [ID_W-1:0] cur_id;
  logic [ID_W-1:0] gnt;
  logic gnt_found;
`ifdef RGB_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] cnt;
`endif
  // Descending scan so the nearest requester after rr_ptr is the last to win.
  always_comb begin
    int idx;
    gnt_found = 1'b0;
    gnt = '0;
    idx = 0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      idx = (int'(rr_ptr) + k) % NUM_REQ;
      if (req_valid[idx]) begin
        gnt_found = 1'b1;
        gnt = ID_W'(idx);
      end
    end
  end
  assign req_ready = (state == IDLE && gnt_found && !rst) ? NUM_REQ'(1) << gnt : '0;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      rr_ptr <= ID_W'(NUM_REQ - 1);
      cur_id <= '0;
      core_input_valid <= 1'b0;
      core_R <= '0;
      core_G <= '0;
      core_B <= '0;
      resp_gray <= '0;
      resp_valid <= '0;
      busy <= 1'b0;
`ifdef RGB_ARB_TIMEOUT_EN
      cnt <= '0;
      err_timeout <= 1'b0;
`endif
    end else begin
`ifdef RGB_ARB_TIMEOUT_EN
      err_timeout <= 1'b0;
`endif
      case (state)
        IDLE: if (gnt_found) begin
          {core_R, core_G, core_B} <= req_rgb[int'(gnt)*24 +: 24];
          cur_id <= gnt;
          rr_ptr <= gnt;
          core_input_valid <= 1'b1;
          busy <= 1'b1;
          state <= ISSUE;
        end
        ISSUE: begin
          core_input_valid <= 1'b0;
`ifdef RGB_ARB_TIMEOUT_EN
          cnt <= '0;
`endif
          state <= WAIT;
        end
        WAIT: if (core_output_valid) begin
          resp_gray <= core_gray;
          resp_valid <= NUM_REQ'(1) << cur_id;
          state <= RESP;
        end
`ifdef RGB_ARB_TIMEOUT_EN
        else if (cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
          err_timeout <= 1'b1;
          resp_gray <= 32'hFFFF_FFFF;
          resp_valid <= NUM_REQ'(1) << cur_id;
          state <= RESP;
        end else cnt <= cnt + 1'b1;
`endif
        RESP: if (resp_ready[cur_id]) begin
          resp_valid <= '0;
          busy <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
